// File: rtl/wrap_clkgen.sv
// Simulation clock generator: N_OUT divided clocks from i_clk with a modelled PLL lock delay.
// Per-channel enables are sampled only at period starts, so gated outputs never produce runt pulses.
//
// There is no encoded state machine. The controller has two phases, selected by o_locked.
//   phase    | meaning
//   locking  | o_locked = 0; lock_cnt counts edges; channel counters are held at 0
//   running  | o_locked = 1; channel counters wrap at D; outputs follow the gated pattern
module wrap_clkgen #(
  parameter int                         N_OUT       = 2,
  parameter int                         DIV_WIDTH   = 8,
  parameter logic [N_OUT*DIV_WIDTH-1:0] DIVS        = {8'd4, 8'd2},
  parameter int                         LOCK_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_pll_rst,
  input  logic [N_OUT-1:0] i_en,
  output logic [N_OUT-1:0] o_clk,
  output logic [N_OUT-1:0] o_tick,
  output logic             o_locked
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);

  if (N_OUT < 1 || N_OUT > 8) begin : g_bad_nout
    $error("wrap_clkgen: N_OUT must be 1..8");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("wrap_clkgen: LOCK_CYCLES must be >= 1");
  end
  for (genvar g = 0; g < N_OUT; g++) begin : g_div_chk
    if (DIVS[g*DIV_WIDTH +: DIV_WIDTH] < 2) begin : g_bad_div
      $error("wrap_clkgen: divisor of channel %0d must be >= 2", g);
    end
  end

  function automatic logic [DIV_WIDTH-1:0] div_of(input int k);
    return DIVS[k*DIV_WIDTH +: DIV_WIDTH];
  endfunction

  logic [LW-1:0]        lock_cnt;
  logic [DIV_WIDTH-1:0] cnt     [N_OUT];
  logic [DIV_WIDTH-1:0] cnt_nxt [N_OUT];
  logic [N_OUT-1:0]     en_q;
  logic [N_OUT-1:0]     en_sel;

  // The enable is re-sampled only when the counter wraps; otherwise the
  // value captured at the period start is held.
  always_comb begin
    en_sel = '0;
    for (int k = 0; k < N_OUT; k++) begin
      cnt_nxt[k] = (cnt[k] == div_of(k) - DIV_WIDTH'(1)) ? '0 : cnt[k] + DIV_WIDTH'(1);
      en_sel[k]  = (cnt_nxt[k] == '0) ? i_en[k] : en_q[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lock_cnt <= '0;
      o_locked <= 1'b0;
      o_clk    <= '0;
      o_tick   <= '0;
      en_q     <= '0;
      for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
    end else if (i_pll_rst) begin
      lock_cnt <= '0;
      o_locked <= 1'b0;
      o_clk    <= '0;
      o_tick   <= '0;
      en_q     <= '0;
      for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
    end else if (!o_locked) begin
      if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
        // The lock edge is period start (cnt = 0) for every channel, and
        // floor(D/2) >= 1, so an enabled output goes high right here.
        lock_cnt <= LW'(LOCK_CYCLES);
        o_locked <= 1'b1;
        en_q     <= i_en;
        o_clk    <= i_en;
        o_tick   <= i_en;
        for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
      end else begin
        lock_cnt <= lock_cnt + LW'(1);
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        cnt[k]    <= cnt_nxt[k];
        en_q[k]   <= en_sel[k];
        o_clk[k]  <= en_sel[k] && (cnt_nxt[k] < (div_of(k) >> 1));
        o_tick[k] <= en_sel[k] && (cnt_nxt[k] == '0);
      end
    end
  end

endmodule

// File: tb/tb_wrap_clkgen.sv
// Randomised bench for wrap_clkgen with three channels (D = 2, 4, 3) against a cycle-index reference model.
module tb_wrap_clkgen;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int LK = 16;
  localparam logic [N*DW-1:0] DV = {8'd3, 8'd4, 8'd2};

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b1;
  logic         i_pll_rst = 1'b0;
  logic [N-1:0] i_en = '0;
  logic [N-1:0] o_clk, o_tick;
  logic         o_locked;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int divs [N] = '{2, 4, 3};

  wrap_clkgen #(.N_OUT(N), .DIV_WIDTH(DW), .DIVS(DV), .LOCK_CYCLES(LK)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_pll_rst(i_pll_rst), .i_en(i_en),
    .o_clk(o_clk), .o_tick(o_tick), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the output is a function of the cycle index n since the lock edge.
  bit           m_locked;
  int           m_low;
  int           m_n;
  bit           m_en_per [N];
  logic [N-1:0] m_clk, m_tick;

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn || i_pll_rst) begin
      m_locked = 1'b0; m_low = 0; m_n = 0; m_clk = '0; m_tick = '0;
    end else begin
      if (!m_locked) begin
        m_low++;
        if (m_low == LK) begin m_locked = 1'b1; m_n = 0; end
      end else begin
        m_n++;
      end
      m_clk = '0; m_tick = '0;
      if (m_locked) begin
        for (int k = 0; k < N; k++) begin
          int ph;
          ph = m_n % divs[k];
          if (ph == 0) m_en_per[k] = i_en[k];
          m_clk[k]  = m_en_per[k] && (ph < divs[k] / 2);
          m_tick[k] = m_en_per[k] && (ph == 0);
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      check("locked", {31'd0, o_locked}, {31'd0, m_locked});
      check("clk",    {29'd0, o_clk},    {29'd0, m_clk});
      check("tick",   {29'd0, o_tick},   {29'd0, m_tick});
    end
  end

  task automatic wait_lock(output int edges);
    edges = 0;
    do begin
      @(posedge i_clk); #1;
      edges++;
    end while (!o_locked && edges < 64);
  endtask

  int edges;

  initial begin
    i_en = '1;
    #1 i_rstn = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_clk", {29'd0, o_clk}, 32'd0);
    check("rst_locked", {31'd0, o_locked}, 32'd0);
    i_rstn = 1'b1;
    wait_lock(edges);
    check("lock_edge", edges, LK);
    check("lock_clk", {29'd0, o_clk}, 32'd7);
    repeat (17) @(negedge i_clk);

    // Drop channel 1 mid-period, then restore it.
    @(negedge i_clk); @(negedge i_clk);
    i_en[1] = 1'b0;
    repeat (10) @(negedge i_clk);
    i_en[1] = 1'b1;
    repeat (10) @(negedge i_clk);

    // One-cycle PLL reset while locked.
    i_pll_rst = 1'b1;
    @(negedge i_clk);
    i_pll_rst = 1'b0;
    check("pll_rst_locked", {31'd0, o_locked}, 32'd0);
    check("pll_rst_clk", {29'd0, o_clk}, 32'd0);
    wait_lock(edges);
    check("relock_edge", edges, LK);
    repeat (12) @(negedge i_clk);

    // Random enables with occasional PLL reset pulses.
    repeat (800) begin
      @(negedge i_clk);
      if ($urandom_range(7) == 0) i_en = N'($urandom);
      i_pll_rst = ($urandom_range(49) == 0);
    end
    @(negedge i_clk);
    i_pll_rst = 1'b0;
    i_en = '1;
    wait_lock(edges);
    repeat (7) @(negedge i_clk);

    // Asynchronous reset away from any clock edge.
    @(posedge i_clk); #3;
    check("pre_async_locked", {31'd0, o_locked}, 32'd1);
    i_rstn = 1'b0;
    #1;
    check("async_clk", {29'd0, o_clk}, 32'd0);
    check("async_tick", {29'd0, o_tick}, 32'd0);
    check("async_locked", {31'd0, o_locked}, 32'd0);
    @(negedge i_clk); @(negedge i_clk);
    i_rstn = 1'b1;
    wait_lock(edges);
    check("lock_edge2", edges, LK);
    repeat (20) @(negedge i_clk);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wrap_clkgen.md
Name: wrap_clkgen

Overview:
- Parametrised simulation-only clock generator; the successor to the pass-through PLL wrapper.
- Derives N_OUT divided clocks from one input clock and models a PLL lock delay.
- Provides per-channel glitch-free enables and rising-edge tick strobes.
- Used under TARGET_SIM so that SoC subsystems at different rates and reset sequencing that depends on lock can be exercised without vendor primitives.

Parameters:
- N_OUT, 2, number of output clock channels (1..8).
- DIV_WIDTH, 8, width of each divisor field.
- DIVS, {8'd4, 8'd2}, packed N_OUT*DIV_WIDTH divisors; channel k uses DIVS[k*DIV_WIDTH +: DIV_WIDTH]. Each divisor must be >= 2, otherwise elaboration fails with $error.
- LOCK_CYCLES, 16, number of i_clk rising edges from reset release to lock. Must be >= 1, otherwise elaboration fails with $error.

Ports:
- i_clk  input  1  source clock; all logic is on the rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_pll_rst  input  1  synchronous active-high PLL reset (models a PLL reset/powerdown pin).
- i_en  input  N_OUT  per-channel output enable.
- o_clk  output  N_OUT  divided clocks, registered.
- o_tick  output  N_OUT  one-i_clk-cycle pulse marking the start of each enabled period.
- o_locked  output  1  high once the lock delay has elapsed.

Behaviour:
- Reset (i_rstn low, asynchronous):
  - o_clk = 0, o_tick = 0, o_locked = 0.
  - Lock counter and all channel counters are cleared.
- Lock counter, width clog2(LOCK_CYCLES+1):
  - Increments on each edge while o_locked = 0 and i_pll_rst = 0.
  - o_locked rises on the edge where the count reaches LOCK_CYCLES, i.e. on the LOCK_CYCLES-th rising edge after i_rstn deasserts.
  - o_locked then stays high until a reset.
- i_pll_rst sampled high on an edge:
  - Same edge: o_locked, o_clk and o_tick go to 0, and the lock counter and channel counters clear.
  - Relock happens LOCK_CYCLES edges after the first edge where i_pll_rst is sampled low.
  - If i_pll_rst is asserted mid-lock, the count restarts from 0.
- Channel counter cnt[k]:
  - Counts 0..D-1, then wraps to 0, where D = DIVS[k].
  - Held at 0 while o_locked = 0.
  - Starts on the lock edge with the output at cnt = 0.
  - All channels are phase-aligned at lock.
- Waveform, for cycle n counted from the lock edge (n = 0):
  - o_clk[k] is high iff (n mod D) < floor(D/2) and the current period is enabled.
  - For odd D the output is high for floor(D/2) cycles and low for ceil(D/2) cycles.
  - Example: D = 2 gives i_clk/2 at 50% duty; D = 3 gives 1 cycle high, 2 low.
- Enable:
  - i_en[k] is sampled only on period-start edges (where cnt wraps to 0, and on the lock edge).
  - If the sampled value is 0, o_clk[k] and o_tick[k] stay 0 for that whole period, but the counter keeps running so phase is preserved.
  - Changing i_en mid-period has no effect until the next period start, so no runt pulses can occur.
- o_tick[k]:
  - High for exactly the cycle in which o_clk[k] rises, i.e. period start of an enabled period.
  - Asserted in the same register stage as o_clk.
- Simultaneous events:
  - i_pll_rst has priority over lock completion and over enable sampling.
  - i_rstn has priority over everything.
- Latency: outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then release, LOCK_CYCLES = 16, i_pll_rst = 0 → o_locked = 0 for 15 edges, rises on the 16th edge. o_clk stays 0 before lock.
- DIVS = {4, 2}, i_en = 2'b11 after lock:
  - o_clk[0] toggles every edge (pattern 1,0,1,0…).
  - o_clk[1] follows pattern 1,1,0,0.
  - Both are high on the lock edge.
  - o_tick[1] pulses once per 4 cycles.
- DIV = 3 → o_clk pattern 1,0,0 repeating; o_tick = 1 on each 1.
- Drop i_en[1] mid-period → the current period completes unchanged. The next period is all-zero with no tick. Re-raising i_en[1] resumes output at a period boundary with the original phase.
- Assert i_pll_rst for 1 cycle while locked → o_locked and all o_clk are 0 on the next edge. Relock occurs exactly 16 edges after i_pll_rst is sampled low, with channels realigned.
- Pull i_rstn low asynchronously mid-period → all outputs clear immediately, without waiting for a clock edge. After release the full lock sequence repeats.
